// File: rtl/seg_pkg.sv
// Shared constants and scan-state type for the seven-segment scan controller.
package seg_pkg;

    localparam int unsigned SEG_W  = 7;
    localparam int unsigned CODE_W = 4;

    localparam logic [CODE_W-1:0] SEG_BLANK  = 4'hF;
    localparam logic [CODE_W-1:0] SEG_BREATH = 4'b1000;

    typedef enum logic {
        SCAN_BLANK = 1'b0,
        SCAN_SHOW  = 1'b1
    } scan_state_e;

endpackage

// File: rtl/seg_shadow_buf.sv
// One-entry shadow register between the update handshake and the active display.
// An accept always wins over a commit because it can only happen while the entry is empty.
module seg_shadow_buf
    import seg_pkg::*;
#(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_change,
    input  logic              commit,
    output logic              ready,
    output logic              full,
    output logic [DATA_W-1:0] data,
    output logic              change
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full   <= 1'b0;
            data   <= {(DATA_W / CODE_W){SEG_BLANK}};
            change <= 1'b0;
        end else if (in_valid && !full) begin
            full   <= 1'b1;
            data   <= in_data;
            change <= in_change;
        end else if (commit) begin
            full   <= 1'b0;
        end
    end

    assign ready = ~full;

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed seven-segment scan controller with frame-synchronous display updates.
// Optional feature: define SEG_BLINK_EN for the breathing "8" blink.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int unsigned NUM_DIG   = 2,
    parameter int unsigned SCAN_DIV  = 50000,
    parameter int unsigned BLANK_CYC = 4,
    parameter int unsigned BLINK_DIV = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      upd_valid,
    output logic                      upd_ready,
    input  logic [CODE_W*NUM_DIG-1:0] upd_data,
    input  logic                      upd_change,
    output logic                      dec_state,
    output logic [CODE_W-1:0]         dec_din,
    input  logic [SEG_W-1:0]          seg_in,
    output logic [SEG_W-1:0]          seg_out,
    output logic [NUM_DIG-1:0]        dig_sel,
    output logic                      frame_tick
);

    localparam int unsigned DATA_W = CODE_W * NUM_DIG;
    localparam int unsigned SLOT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned IDX_W  = (NUM_DIG > 1) ? $clog2(NUM_DIG) : 1;

    localparam logic [SLOT_W-1:0] SLOT_LAST  = SLOT_W'(SCAN_DIV - 1);
    localparam logic [SLOT_W-1:0] BLANK_LAST = SLOT_W'(BLANK_CYC - 1);
    localparam logic [IDX_W-1:0]  DIG_LAST   = IDX_W'(NUM_DIG - 1);

    if (NUM_DIG < 2 || BLANK_CYC < 1 || SCAN_DIV <= BLANK_CYC || BLINK_DIV < 1) begin : g_bad_cfg
        $error("seg_scan_ctrl: illegal parameter combination");
    end

    scan_state_e       state, state_nxt;
    logic [SLOT_W-1:0] slot_cnt, slot_nxt;
    logic [IDX_W-1:0]  dig_idx, dig_nxt;
    logic              wrap;
    logic [DATA_W-1:0] active, active_nxt;
    logic              active_change, change_nxt;
    logic [CODE_W-1:0] din_nxt;
    logic [NUM_DIG-1:0] sel_nxt;
    logic              sh_full, sh_change;
    logic [DATA_W-1:0] sh_data;
    logic              blink_mask;

    seg_shadow_buf #(.DATA_W(DATA_W)) u_shadow (
        .clk      (clk),
        .rst      (rst),
        .in_valid (upd_valid),
        .in_data  (upd_data),
        .in_change(upd_change),
        .commit   (wrap),
        .ready    (upd_ready),
        .full     (sh_full),
        .data     (sh_data),
        .change   (sh_change)
    );

    // Slot sequencing, frame wrap and commit of the shadow into the active set
    always_comb begin
        state_nxt  = state;
        slot_nxt   = slot_cnt + 1'b1;
        dig_nxt    = dig_idx;
        wrap       = 1'b0;
        case (state)
            SCAN_BLANK: if (slot_cnt == BLANK_LAST) state_nxt = SCAN_SHOW;
            SCAN_SHOW: begin
                if (slot_cnt == SLOT_LAST) begin
                    state_nxt = SCAN_BLANK;
                    slot_nxt  = '0;
                    if (dig_idx == DIG_LAST) begin
                        dig_nxt = '0;
                        wrap    = 1'b1;
                    end else begin
                        dig_nxt = dig_idx + 1'b1;
                    end
                end
            end
            default: state_nxt = SCAN_BLANK;
        endcase
        active_nxt = (wrap && sh_full) ? sh_data   : active;
        change_nxt = (wrap && sh_full) ? sh_change : active_change;
        din_nxt    = active_nxt[32'(dig_nxt) * CODE_W +: CODE_W];
        sel_nxt    = (state_nxt == SCAN_SHOW) ? (NUM_DIG'(1) << dig_nxt) : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= SCAN_BLANK;
            slot_cnt      <= '0;
            dig_idx       <= '0;
            active        <= {NUM_DIG{SEG_BLANK}};
            active_change <= 1'b0;
            dec_din       <= SEG_BLANK;
            dig_sel       <= '0;
            frame_tick    <= 1'b0;
        end else begin
            state         <= state_nxt;
            slot_cnt      <= slot_nxt;
            dig_idx       <= dig_nxt;
            active        <= active_nxt;
            active_change <= change_nxt;
            dec_din       <= din_nxt;
            dig_sel       <= sel_nxt;
            frame_tick    <= wrap;
        end
    end

`ifdef SEG_BLINK_EN
    localparam int unsigned FRM_W = $clog2(BLINK_DIV + 1);

    logic [FRM_W-1:0] frm_cnt;
    logic             blink_phase;

    // Blink phase flips every BLINK_DIV frames
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frm_cnt     <= '0;
            blink_phase <= 1'b0;
        end else if (wrap) begin
            if (frm_cnt == FRM_W'(BLINK_DIV - 1)) begin
                frm_cnt     <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                frm_cnt     <= frm_cnt + 1'b1;
            end
        end
    end

    // dec_din always holds the active code of the digit being scanned
    assign blink_mask = blink_phase && (dec_din == SEG_BREATH);
`else
    assign blink_mask = 1'b0;
`endif

    assign dec_state = active_change;
    assign seg_out   = (state == SCAN_SHOW && !blink_mask) ? seg_in : '0;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl: directed scenarios plus random updates,
// compared every cycle against a frame-level model of the display.
module tb_seg_scan_ctrl;

    localparam int unsigned NUM_DIG   = 2;
    localparam int unsigned SCAN_DIV  = 8;
    localparam int unsigned BLANK_CYC = 2;
    localparam int unsigned BLINK_DIV = 2;
    localparam int unsigned FRAME     = NUM_DIG * SCAN_DIV;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       upd_valid = 1'b0;
    logic       upd_ready;
    logic [7:0] upd_data = 8'h00;
    logic       upd_change = 1'b0;
    logic       dec_state;
    logic [3:0] dec_din;
    logic [6:0] seg_in = 7'h00;
    logic [6:0] seg_out;
    logic [1:0] dig_sel;
    logic       frame_tick;

    int checks = 0;
    int errors = 0;

    // Model: cycles since reset release, displayed contents and one pending update
    int         t = 0;
    logic [7:0] disp = 8'hFF;
    bit         disp_chg = 1'b0;
    bit         pend = 1'b0;
    logic [7:0] pend_data = 8'h00;
    bit         pend_chg = 1'b0;

    seg_scan_ctrl #(
        .NUM_DIG  (NUM_DIG),
        .SCAN_DIV (SCAN_DIV),
        .BLANK_CYC(BLANK_CYC),
        .BLINK_DIV(BLINK_DIV)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .upd_valid (upd_valid),
        .upd_ready (upd_ready),
        .upd_data  (upd_data),
        .upd_change(upd_change),
        .dec_state (dec_state),
        .dec_din   (dec_din),
        .seg_in    (seg_in),
        .seg_out   (seg_out),
        .dig_sel   (dig_sel),
        .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s t=%0d observed=%h expected=%h", tag, t, got, exp);
        end
    endtask

    task automatic model_reset();
        t = 0; disp = 8'hFF; disp_chg = 1'b0; pend = 1'b0;
    endtask

    task automatic check_all();
        int         p, d, f;
        bit         show, dark;
        logic [3:0] e_din;
        logic [1:0] e_sel;
        logic [6:0] e_seg;
        p     = t % SCAN_DIV;
        d     = (t / SCAN_DIV) % NUM_DIG;
        f     = t / FRAME;
        show  = (p >= BLANK_CYC);
        e_din = disp[d*4 +: 4];
        e_sel = show ? (2'b01 << d) : 2'b00;
`ifdef SEG_BLINK_EN
        dark  = (((f / BLINK_DIV) % 2) == 1) && (e_din == 4'b1000);
`else
        dark  = 1'b0;
`endif
        e_seg = (show && !dark) ? seg_in : 7'h00;
        chk("dig_sel",    8'(dig_sel),    8'(e_sel));
        chk("seg_out",    8'(seg_out),    8'(e_seg));
        chk("dec_din",    8'(dec_din),    8'(e_din));
        chk("dec_state",  8'(dec_state),  8'(disp_chg));
        chk("upd_ready",  8'(upd_ready),  8'(!pend));
        chk("frame_tick", 8'(frame_tick), 8'(t > 0 && p == 0 && d == 0));
    endtask

    // One clock: model applies frame commit, then any accept, then compares
    task automatic step();
        bit acc;
        acc = upd_valid && !pend;
        @(posedge clk);
        #1;
        t++;
        if (t % FRAME == 0 && pend) begin
            disp = pend_data; disp_chg = pend_chg; pend = 1'b0;
        end
        if (acc) begin
            pend = 1'b1; pend_data = upd_data; pend_chg = upd_change;
            upd_valid = 1'b0;
        end
        seg_in = 7'($urandom);
        #1;
        check_all();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_phase(input int ph);
        int n = 0;
        while ((t % FRAME) != ph && n < FRAME) begin
            step();
            n++;
        end
    endtask

    task automatic offer(input logic [7:0] d, input bit c);
        int n = 0;
        upd_data = d; upd_change = c; upd_valid = 1'b1;
        while (upd_valid && n < 4 * FRAME) begin
            step();
            n++;
        end
        checks++;
        assert (!upd_valid)
        else begin
            errors++;
            $error("FAIL offer_timeout data=%h observed=stalled expected=accepted", d);
            upd_valid = 1'b0;
        end
    endtask

    initial begin
        seg_in = 7'($urandom);
        repeat (3) @(posedge clk);
        #1;
        model_reset();
        check_all();
        rst = 1'b0;
        seg_in = 7'($urandom);
        #1;
        check_all();

        // Idle scan with reset contents
        run(2 * FRAME);

        // Single update mid-frame
        wait_phase(5);
        offer(8'h53, 1'b0);
        run(2 * FRAME);

        // Back-to-back offers: second stalls until the boundary
        wait_phase(3);
        offer(8'h12, 1'b0);
        offer(8'h34, 1'b0);
        run(2 * FRAME);

        // Change mode with dash code on digit 1
        offer(8'hF0, 1'b1);
        run(2 * FRAME);

        // Breathing 8 on digit 0
        offer(8'h08, 1'b0);
        run(5 * FRAME);

        // Random updates at random gaps
        for (int k = 0; k < 8; k++) begin
            run(int'($urandom_range(0, 20)));
            offer(8'($urandom), 1'($urandom));
        end
        run(2 * FRAME);

        // Reset in SHOW of digit 1 with the shadow holding an unseen update
        offer(8'h97, 1'b1);
        run(FRAME);
        wait_phase(1);
        offer(8'hAB, 1'b1);
        wait_phase(12);
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        #1;
        rst = 1'b0;
        seg_in = 7'($urandom);
        #1;
        check_all();
        run(3 * FRAME);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
